// File: rtl/grain_pkg.sv
// Shared types and defaults for the Grain stream controller.
// State encoding plus seed width and parameter defaults.
package grain_pkg;

  localparam int SEED_W     = 104;
  localparam int DEF_WARMUP = 160;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_WAIT_IN,
    S_CRYPT,
    S_OUT,
    S_FIN
  } state_t;

endpackage

// File: rtl/grain_bit_serializer.sv
// Bit-serial XOR of one data word against the keystream, LSB first.
// Holds the work word, bit counter and the registered result.
module grain_bit_serializer
  import grain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              shift,
  input  logic              ks_bit,
  output logic [DATA_W-1:0] result,
  output logic              last
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] work;
  logic [BW-1:0]     bit_cnt;

  // Latch a new word, then combine one bit per shift cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      work    <= '0;
      bit_cnt <= '0;
      result  <= '0;
    end else if (load) begin
      work    <= in_data;
      bit_cnt <= '0;
      result  <= '0;
    end else if (shift) begin
      result[bit_cnt] <= work[bit_cnt] ^ ks_bit;
      bit_cnt         <= bit_cnt + BW'(1);
    end
  end

  // Final bit of the word is being processed this cycle
  always_comb begin
    last = (bit_cnt == BW'(DATA_W - 1));
  end

endmodule

// File: rtl/grain_stream_ctrl.sv
// Sequencer for the Grain keystream generator: seed load, warm-up,
// then byte-stream XOR with valid/ready on both sides.
module grain_stream_ctrl
  import grain_pkg::*;
#(
  parameter int WARMUP_CYCLES = DEF_WARMUP,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int LEN_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEED_W-1:0] seed,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              g_par_load,
  output logic              g_shift_en,
  output logic [SEED_W-1:0] g_seed,
  input  logic              g_ks_bit
);

  localparam int WW = $clog2(WARMUP_CYCLES + 1);

  state_t            state;
  state_t            state_n;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_cnt;
  logic [WW-1:0]     warm_cnt;
  logic              warm_done;
  logic              len_zero;
  logic              word_last;
  logic              bit_last;

  assign warm_done = (warm_cnt == WW'(WARMUP_CYCLES - 1));
  assign len_zero  = (len_q == '0);
  assign word_last = (word_cnt == len_q - LEN_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Session captures and warm-up / word counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      g_seed   <= '0;
      len_q    <= '0;
      word_cnt <= '0;
      warm_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          g_seed   <= seed;
          len_q    <= msg_len;
          word_cnt <= '0;
        end
        S_LOAD:  warm_cnt <= '0;
        S_WARM:  warm_cnt <= warm_cnt + WW'(1);
        S_OUT:   if (out_ready) word_cnt <= word_cnt + LEN_W'(1);
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (start) state_n = S_LOAD;
      S_LOAD:    state_n = S_WARM;
      S_WARM:    if (warm_done) state_n = len_zero ? S_FIN : S_WAIT_IN;
      S_WAIT_IN: if (in_valid) state_n = S_CRYPT;
      S_CRYPT:   if (bit_last) state_n = S_OUT;
      S_OUT:     if (out_ready) state_n = word_last ? S_FIN : S_WAIT_IN;
      S_FIN:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    g_par_load = 1'b0;
    g_shift_en = 1'b0;
    unique case (state)
      S_IDLE:    busy       = 1'b0;
      S_LOAD:    g_par_load = 1'b1;
      S_WARM:    g_shift_en = 1'b1;
      S_WAIT_IN: in_ready   = 1'b1;
      S_CRYPT:   g_shift_en = 1'b1;
      S_OUT:     out_valid  = 1'b1;
      S_FIN:     done       = 1'b1;
      default:   busy       = 1'b0;
    endcase
  end

  grain_bit_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (in_ready & in_valid),
    .in_data (in_data),
    .shift   (state == S_CRYPT),
    .ks_bit  (g_ks_bit),
    .result  (out_data),
    .last    (bit_last)
  );

endmodule

// File: tb/tb_grain_stream_ctrl.sv
// Directed bench for grain_stream_ctrl with a stubbed keystream.
// Keystream is either constant 1 or alternating 1,0,1,0 per shift.
module tb_grain_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [103:0] seed;
  logic [15:0]  msg_len;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         g_par_load;
  logic         g_shift_en;
  logic [103:0] g_seed;
  logic         g_ks_bit;

  int total = 0;
  int bad   = 0;

  int          shift_cnt = 0;
  int          ks_base   = 0;
  logic        ks_mode   = 1'b0;
  logic [31:0] diff;

  localparam logic [103:0] SEED_A = 104'h0123456789ABCDEF0123456789;
  localparam logic [103:0] SEED_B = 104'hFEDCBA9876543210FEDCBA9876;

  grain_stream_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .msg_len    (msg_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .g_par_load (g_par_load),
    .g_shift_en (g_shift_en),
    .g_seed     (g_seed),
    .g_ks_bit   (g_ks_bit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (g_shift_en) shift_cnt <= shift_cnt + 1;
  end

  assign diff     = shift_cnt - ks_base;
  assign g_ks_bit = ks_mode ? ~diff[0] : 1'b1;

  task automatic do_start(input logic [103:0] s, input logic [15:0] n);
    seed    = s;
    msg_len = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] exp,
                           input int hold, input string nm);
    int k;
    int lat;
    int errs;
    k = 0;
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL %s_ready: in_ready=%0b want 1", nm, in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL %s_lat: got %0d want 8", nm, lat);
    end
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL %s_data: got %h want %h", nm, out_data, exp);
    end
    if (hold > 0) begin
      errs = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== exp ||
            g_shift_en !== 1'b0 || in_ready !== 1'b0) errs++;
      end
      total++;
      if (errs !== 0) begin
        bad++;
        $display("FAIL %s_hold: got %0d bad cycles want 0", nm, errs);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    int k;
    n = 0;
    k = 0;
    while (busy && k < 50) begin
      if (done) n++;
      @(negedge clk);
      k++;
    end
    total++;
    if (n !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_done: pulses=%0d busy=%0b want 1/0", nm, n, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, done, g_par_load, g_shift_en} !== 6'b0 ||
        g_seed !== '0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset: ctl=%b seed=%h data=%h want 0",
        {in_ready, out_valid, busy, done, g_par_load, g_shift_en},
        g_seed, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timing();
    int cyc, par_n, par_first, sh_n, sh_first, both;
    logic seen;
    ks_mode = 1'b0;
    par_n = 0; par_first = -1; sh_n = 0; sh_first = -1; both = 0;
    seen = 1'b0;
    do_start(SEED_A, 16'd1);
    cyc = 1;
    for (int k = 0; k < 400; k++) begin
      if (g_par_load) begin
        par_n++;
        if (par_first < 0) par_first = cyc;
      end
      if (g_shift_en) begin
        sh_n++;
        if (sh_first < 0) sh_first = cyc;
      end
      if (g_par_load && g_shift_en) both++;
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!seen || cyc !== 162) begin
      bad++;
      $display("FAIL tim_ready: cycle=%0d want 162", cyc);
    end
    total++;
    if (par_n !== 1 || par_first !== 1) begin
      bad++;
      $display("FAIL tim_load: n=%0d at %0d want 1 at 1", par_n, par_first);
    end
    total++;
    if (sh_n !== 160 || sh_first !== 2) begin
      bad++;
      $display("FAIL tim_warm: n=%0d at %0d want 160 at 2", sh_n, sh_first);
    end
    total++;
    if (both !== 0) begin
      bad++;
      $display("FAIL tim_both: got %0d want 0", both);
    end
    total++;
    if (g_seed !== SEED_A) begin
      bad++;
      $display("FAIL tim_seed: got %h want %h", g_seed, SEED_A);
    end
    send_word(8'h00, 8'hFF, 0, "tim_w0");
    wait_done("tim");
  endtask

  task automatic test_back_to_back();
    ks_mode = 1'b0;
    do_start(SEED_B, 16'd2);
    send_word(8'hA5, 8'h5A, 0, "b2b_w0");
    send_word(8'h3C, 8'hC3, 0, "b2b_w1");
    wait_done("b2b");
  endtask

  task automatic test_lsb_first();
    ks_mode = 1'b1;
    ks_base = shift_cnt;
    do_start(SEED_A, 16'd1);
    send_word(8'h00, 8'h55, 0, "lsb_w0");
    wait_done("lsb");
  endtask

  task automatic test_backpressure();
    ks_mode = 1'b1;
    ks_base = shift_cnt;
    do_start(SEED_B, 16'd2);
    send_word(8'h00, 8'h55, 20, "bp_w0");
    send_word(8'h0F, 8'h5A, 0, "bp_w1");
    wait_done("bp");
    total++;
    if (diff !== 32'd176) begin
      bad++;
      $display("FAIL bp_shifts: got %0d want 176", diff);
    end
  endtask

  task automatic test_zero_len();
    int cyc, done_n, done_cyc, idle_cyc, ir_n;
    done_n = 0; done_cyc = -1; idle_cyc = -1; ir_n = 0;
    ks_base = shift_cnt;
    do_start(SEED_A, 16'd0);
    cyc = 1;
    for (int k = 0; k < 400; k++) begin
      if (in_ready) ir_n++;
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
      if (cyc >= 10 && cyc < 20) begin
        start   = 1'b1;
        seed    = SEED_B;
        msg_len = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total++;
    if (ir_n !== 0) begin
      bad++;
      $display("FAIL zl_ready: got %0d cycles want 0", ir_n);
    end
    total++;
    if (done_n !== 1 || done_cyc !== 162) begin
      bad++;
      $display("FAIL zl_done: n=%0d at %0d want 1 at 162", done_n, done_cyc);
    end
    total++;
    if (idle_cyc !== 163) begin
      bad++;
      $display("FAIL zl_idle: got %0d want 163", idle_cyc);
    end
    total++;
    if (diff !== 32'd160) begin
      bad++;
      $display("FAIL zl_shifts: got %0d want 160", diff);
    end
    total++;
    if (g_seed !== SEED_A) begin
      bad++;
      $display("FAIL zl_seed: got %h want %h", g_seed, SEED_A);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int cyc;
    ks_mode = 1'b0;
    do_start(SEED_B, 16'd1);
    k = 0;
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (g_shift_en !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rm_crypt: shift=%0b valid=%0b want 1/0",
        g_shift_en, out_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, done, g_par_load, g_shift_en} !== 6'b0 ||
        g_seed !== '0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL rm_reset: ctl=%b seed=%h data=%h want 0",
        {in_ready, out_valid, busy, done, g_par_load, g_shift_en},
        g_seed, out_data);
    end
    rst = 1'b1;
    ks_base = shift_cnt;
    do_start(SEED_A, 16'd1);
    total++;
    if (g_par_load !== 1'b1) begin
      bad++;
      $display("FAIL rm_load: got %0b want 1", g_par_load);
    end
    cyc = 1;
    while (!in_ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== 162 || diff !== 32'd160) begin
      bad++;
      $display("FAIL rm_rerun: ready at %0d shifts=%0d want 162/160",
        cyc, diff);
    end
    send_word(8'h3C, 8'hC3, 0, "rm_w0");
    wait_done("rm");
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    seed      = '0;
    msg_len   = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_timing();
    test_back_to_back();
    test_lsb_first();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grain_stream_ctrl.md
Name: grain_stream_ctrl

Overview:
Sequencer for the 104-bit Grain keystream generator. It loads the seed, runs the mandatory warm-up shifts with the output discarded, then encrypts/decrypts a byte stream by XORing each data bit with one keystream bit. It sits between a byte-wide valid/ready producer/consumer pair and the generator, and drives the generator's Par_load and shift_en. The generator instance lives beside this block, not inside it.

Parameters:
WARMUP_CYCLES, 160, number of discarded keystream shifts after seed load (1..4095)
DATA_W, 8, bits per data word
LEN_W, 16, width of message-length field (words)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge)
start  in  1  begin a session; sampled only in IDLE
seed  in  104  session seed, captured on accepted start
msg_len  in  LEN_W  number of words in session, captured on accepted start
in_data  in  DATA_W  plaintext/ciphertext word
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  DATA_W  processed word, registered
out_valid  out  1  out_data valid, held until out_ready
out_ready  in  1  consumer accepts out_data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at session end
g_par_load  out  1  to generator Par_load
g_shift_en  out  1  to generator shift_en
g_seed  out  104  to generator Seed; registered copy of seed
g_ks_bit  in  1  generator keystream output (combinational from its current state)

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs 0; g_seed, out_data, counters cleared. Reset overrides every state, including mid-warm-up and mid-word.
- States: IDLE, LOAD, WARM, WAIT_IN, CRYPT, OUT, FIN.
- IDLE: start=1 -> capture seed and msg_len, go to LOAD. In every other state start is ignored.
- LOAD: g_par_load=1 for exactly one cycle, g_shift_en=0 -> WARM. warm_cnt cleared.
- WARM: g_shift_en=1 each cycle; g_ks_bit ignored; after exactly WARMUP_CYCLES cycles -> WAIT_IN, or FIN if captured msg_len==0.
- WAIT_IN: in_ready=1. A handshake (in_valid&in_ready) latches in_data into a work register, clears bit_cnt -> CRYPT. g_shift_en=0 while waiting, so the keystream does not advance.
- CRYPT: DATA_W cycles with g_shift_en=1. On cycle i (i=0 first), result bit i = work bit i XOR g_ks_bit sampled that cycle, LSB first; the generator shifts at the same edge. After bit DATA_W-1 -> OUT, with out_data registered and out_valid=1.
- OUT: out_valid held, out_data stable, g_shift_en=0 until out_ready=1. On handshake, word_cnt++. If word_cnt reaches msg_len -> FIN, else -> WAIT_IN. No overlap: in_ready=0 while in OUT.
- FIN: done=1 for one cycle, busy=1 -> IDLE.
- Timing from an accepted start at edge 0: LOAD during cycle 1; WARM during cycles 2..WARMUP_CYCLES+1; in_ready first high in cycle WARMUP_CYCLES+2. Per-word minimum: 1 input cycle + DATA_W crypt cycles + 1 output cycle.
- Counters: warm_cnt has width clog2(WARMUP_CYCLES+1), bit_cnt has width clog2(DATA_W), word_cnt has width LEN_W. There is no wrap-around because msg_len bounds word_cnt.
- g_par_load and g_shift_en are never both 1.

Decomposition:
- Package grain_pkg contains the state enum, SEED_W=104, and default WARMUP_CYCLES/DATA_W.
- One sub-module, grain_bit_serializer, holds the DATA_W work register, bit_cnt, the XOR, and the result register. The FSM and counters stay in grain_stream_ctrl.

Test Plan:
- Start with seed=0x0123456789ABCDEF0123456789, msg_len=1 -> g_par_load high exactly 1 cycle (cycle 1), g_shift_en high exactly 160 consecutive cycles, in_ready first high at cycle 162, g_seed equals the seed.
- Stub g_ks_bit=1 constant, send 0xA5, 0x3C with msg_len=2 -> out_data 0x5A then 0xC3, done pulses once, busy returns to 0.
- Stub g_ks_bit alternating 1,0,1,0 per shift cycle (warm-up ends on an even count) and send 0x00 -> out_data 0x55, confirming LSB-first ordering.
- Hold out_ready=0 for 20 cycles after out_valid -> out_data stable, g_shift_en=0, in_ready=0 throughout. On release, the next word proceeds with no keystream bit skipped.
- msg_len=0 -> LOAD, 160 warm cycles, then done with no in_ready ever asserted. A start asserted while busy is ignored.
- Drive rst=0 during CRYPT bit 3 -> next cycle state is IDLE and all outputs are 0. A subsequent start runs a full LOAD/WARM sequence again.
